// File: rtl/axi4_wb_bridge.sv
// AXI4 responder replaying each burst beat as one Wishbone classic cycle.
// Optional WRAP burst support is enabled by defining AXI_WB_WRAP_EN.
`timescale 1ns/1ps
module axi4_wb_bridge #(
    parameter int ID_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                axi_awvalid_i,
    output logic                axi_awready_o,
    input  logic [31:0]         axi_awaddr_i,
    input  logic [ID_WIDTH-1:0] axi_awid_i,
    input  logic [7:0]          axi_awlen_i,
    input  logic [1:0]          axi_awburst_i,
    input  logic                axi_wvalid_i,
    output logic                axi_wready_o,
    input  logic [31:0]         axi_wdata_i,
    input  logic [3:0]          axi_wstrb_i,
    input  logic                axi_wlast_i,
    output logic                axi_bvalid_o,
    input  logic                axi_bready_i,
    output logic [1:0]          axi_bresp_o,
    output logic [ID_WIDTH-1:0] axi_bid_o,
    input  logic                axi_arvalid_i,
    output logic                axi_arready_o,
    input  logic [31:0]         axi_araddr_i,
    input  logic [ID_WIDTH-1:0] axi_arid_i,
    input  logic [7:0]          axi_arlen_i,
    input  logic [1:0]          axi_arburst_i,
    output logic                axi_rvalid_o,
    input  logic                axi_rready_i,
    output logic [31:0]         axi_rdata_o,
    output logic [1:0]          axi_rresp_o,
    output logic [ID_WIDTH-1:0] axi_rid_o,
    output logic                axi_rlast_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [3:0]          wb_sel_o,
    output logic [31:0]         wb_addr_o,
    output logic [31:0]         wb_data_o,
    input  logic [31:0]         wb_data_i,
    input  logic                wb_ack_i
);

    typedef enum logic [2:0] {
        IDLE, WR_DATA, WR_BUS, WR_RESP, RD_BUS, RD_RESP
    } state_t;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam bit          TMO_EN      = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TMO_LAST    = 32'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [31:0]           addr_q, addr_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [7:0]            len_q, len_d;
    logic [1:0]            burst_q, burst_d;
    logic [7:0]            beat_q, beat_d;
    logic                  err_q, err_d;
    logic                  rerr_q, rerr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            strb_q, strb_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [31:0]           tmo_q, tmo_d;
    logic                  lww_q, lww_d;

    logic                  idle;
    logic                  aw_go;
    logic                  ar_go;
    logic                  last_beat;
    logic                  tmo_hit;
    logic                  bad_burst;
    logic [31:0]           addr_nxt;

    assign idle      = (state_q == IDLE);
    // Arbitration: on a tie, serve the direction not served last time.
    assign aw_go     = idle && axi_awvalid_i && (!axi_arvalid_i || !lww_q);
    assign ar_go     = idle && axi_arvalid_i && !aw_go;
    assign last_beat = (beat_q == len_q);
    assign tmo_hit   = TMO_EN && (tmo_q == TMO_LAST);

`ifdef AXI_WB_WRAP_EN
    logic [31:0] wrap_mask;
    assign wrap_mask = {22'd0, len_q, 2'b11};
`endif

    always_comb begin
        bad_burst = 1'b0;
        unique case (burst_q)
            2'b00, 2'b01: bad_burst = 1'b0;
`ifdef AXI_WB_WRAP_EN
            2'b10: bad_burst = !(len_q inside {8'd1, 8'd3, 8'd7, 8'd15});
`else
            2'b10: bad_burst = 1'b1;
`endif
            default: bad_burst = 1'b1;
        endcase
    end

    // Unsupported bursts fall back to FIXED addressing.
    always_comb begin
        addr_nxt = addr_q;
        if (!bad_burst) begin
            if (burst_q == BURST_INCR) begin
                addr_nxt = addr_q + 32'd4;
            end
`ifdef AXI_WB_WRAP_EN
            else if (burst_q == 2'b10) begin
                addr_nxt = (addr_q & ~wrap_mask) |
                           ((addr_q + 32'd4) & wrap_mask);
            end
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        id_d    = id_q;
        len_d   = len_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        err_d   = err_q;
        rerr_d  = rerr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        rdata_d = rdata_q;
        tmo_d   = tmo_q;
        lww_d   = lww_q;
        unique case (state_q)
            IDLE: begin
                if (aw_go) begin
                    state_d = WR_DATA;
                    addr_d  = axi_awaddr_i;
                    id_d    = axi_awid_i;
                    len_d   = axi_awlen_i;
                    burst_d = axi_awburst_i;
                    beat_d  = 8'd0;
                    err_d   = 1'b0;
                    lww_d   = 1'b1;
                end else if (ar_go) begin
                    state_d = RD_BUS;
                    addr_d  = axi_araddr_i;
                    id_d    = axi_arid_i;
                    len_d   = axi_arlen_i;
                    burst_d = axi_arburst_i;
                    beat_d  = 8'd0;
                    err_d   = 1'b0;
                    lww_d   = 1'b0;
                end
            end
            WR_DATA: begin
                if (axi_wvalid_i) begin
                    wdata_d = axi_wdata_i;
                    strb_d  = axi_wstrb_i;
                    if (axi_wlast_i != last_beat) begin
                        err_d = 1'b1;
                    end
                    state_d = WR_BUS;
                end
            end
            WR_BUS: begin
                if (wb_ack_i || tmo_hit) begin
                    tmo_d = 32'd0;
                    if (!wb_ack_i || bad_burst) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = WR_RESP;
                    end else begin
                        addr_d  = addr_nxt;
                        beat_d  = beat_q + 8'd1;
                        state_d = WR_DATA;
                    end
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            WR_RESP: begin
                if (axi_bready_i) begin
                    state_d = IDLE;
                end
            end
            RD_BUS: begin
                if (wb_ack_i || tmo_hit) begin
                    tmo_d   = 32'd0;
                    rdata_d = wb_ack_i ? wb_data_i : 32'd0;
                    rerr_d  = !wb_ack_i || bad_burst;
                    state_d = RD_RESP;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            RD_RESP: begin
                if (axi_rready_i) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_nxt;
                        beat_d  = beat_q + 8'd1;
                        state_d = RD_BUS;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            id_q    <= '0;
            len_q   <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            rerr_q  <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            tmo_q   <= '0;
            lww_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            rerr_q  <= rerr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
            lww_q   <= lww_d;
        end
    end

    assign axi_awready_o = !rst_i && aw_go;
    assign axi_arready_o = !rst_i && ar_go;
    assign axi_wready_o  = (state_q == WR_DATA);
    assign axi_bvalid_o  = (state_q == WR_RESP);
    assign axi_bresp_o   = err_q ? RESP_SLVERR : RESP_OKAY;
    assign axi_bid_o     = id_q;
    assign axi_rvalid_o  = (state_q == RD_RESP);
    assign axi_rdata_o   = rdata_q;
    assign axi_rresp_o   = rerr_q ? RESP_SLVERR : RESP_OKAY;
    assign axi_rid_o     = id_q;
    assign axi_rlast_o   = (state_q == RD_RESP) && last_beat;

    assign wb_cyc_o  = (state_q == WR_BUS) || (state_q == RD_BUS);
    assign wb_stb_o  = wb_cyc_o;
    assign wb_we_o   = (state_q == WR_BUS);
    assign wb_sel_o  = (state_q == WR_BUS) ? strb_q :
                       (state_q == RD_BUS) ? 4'hF : 4'h0;
    assign wb_addr_o = {addr_q[31:2], 2'b00};
    assign wb_data_o = wdata_q;

endmodule

// File: tb/tb_axi4_wb_bridge.sv
// Directed bench for axi4_wb_bridge with a behavioural Wishbone responder.
`timescale 1ns/1ps
module tb_axi4_wb_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        axi_awvalid_i, axi_awready_o;
    logic [31:0] axi_awaddr_i;
    logic [3:0]  axi_awid_i;
    logic [7:0]  axi_awlen_i;
    logic [1:0]  axi_awburst_i;
    logic        axi_wvalid_i, axi_wready_o;
    logic [31:0] axi_wdata_i;
    logic [3:0]  axi_wstrb_i;
    logic        axi_wlast_i;
    logic        axi_bvalid_o, axi_bready_i;
    logic [1:0]  axi_bresp_o;
    logic [3:0]  axi_bid_o;
    logic        axi_arvalid_i, axi_arready_o;
    logic [31:0] axi_araddr_i;
    logic [3:0]  axi_arid_i;
    logic [7:0]  axi_arlen_i;
    logic [1:0]  axi_arburst_i;
    logic        axi_rvalid_o, axi_rready_i;
    logic [31:0] axi_rdata_o;
    logic [1:0]  axi_rresp_o;
    logic [3:0]  axi_rid_o;
    logic        axi_rlast_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_addr_o, wb_data_o, wb_data_i;
    logic        wb_ack_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic        ack_en;
    int          ack_delay;
    logic [31:0] rd_base;
    int          n_log;
    int          stb_cnt;
    logic [31:0] log_addr[16];
    logic [3:0]  log_sel[16];
    logic [31:0] log_data[16];
    logic        log_we[16];

    always #5 clk_i = ~clk_i;

    axi4_wb_bridge #(.ID_WIDTH(4), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o),
        .axi_awaddr_i(axi_awaddr_i), .axi_awid_i(axi_awid_i),
        .axi_awlen_i(axi_awlen_i), .axi_awburst_i(axi_awburst_i),
        .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o),
        .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i),
        .axi_wlast_i(axi_wlast_i),
        .axi_bvalid_o(axi_bvalid_o), .axi_bready_i(axi_bready_i),
        .axi_bresp_o(axi_bresp_o), .axi_bid_o(axi_bid_o),
        .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
        .axi_araddr_i(axi_araddr_i), .axi_arid_i(axi_arid_i),
        .axi_arlen_i(axi_arlen_i), .axi_arburst_i(axi_arburst_i),
        .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i),
        .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
        .axi_rid_o(axi_rid_o), .axi_rlast_o(axi_rlast_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_addr_o(wb_addr_o),
        .wb_data_o(wb_data_o), .wb_data_i(wb_data_i),
        .wb_ack_i(wb_ack_i)
    );

    // Wishbone responder: acks after ack_delay wait cycles, logs every access.
    initial begin : responder
        int wcnt;
        wcnt      = 0;
        wb_ack_i  = 1'b0;
        wb_data_i = 32'd0;
        forever begin
            @(negedge clk_i);
            wb_ack_i = 1'b0;
            if (wb_cyc_o && wb_stb_o) begin
                stb_cnt++;
                if (ack_en && wcnt >= ack_delay) begin
                    wb_ack_i  = 1'b1;
                    wb_data_i = rd_base + 32'(n_log);
                    if (n_log < 16) begin
                        log_addr[n_log] = wb_addr_o;
                        log_sel[n_log]  = wb_sel_o;
                        log_data[n_log] = wb_data_o;
                        log_we[n_log]   = wb_we_o;
                    end
                    n_log++;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [3:0] id,
                           input logic [7:0] len, input logic [1:0] b);
        bit ok;
        ok = 1'b0;
        axi_araddr_i  = a;
        axi_arid_i    = id;
        axi_arlen_i   = len;
        axi_arburst_i = b;
        axi_arvalid_i = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (axi_arready_o) ok = 1'b1;
            tick();
        end
        axi_arvalid_i = 1'b0;
        n_checks++;
        if (!ok) begin
            $display("FAIL ar_handshake: arready=0 required 1 addr=%h", a);
            n_fail++;
        end
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [3:0] id,
                           input logic [7:0] len, input logic [1:0] b);
        bit ok;
        ok = 1'b0;
        axi_awaddr_i  = a;
        axi_awid_i    = id;
        axi_awlen_i   = len;
        axi_awburst_i = b;
        axi_awvalid_i = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (axi_awready_o) ok = 1'b1;
            tick();
        end
        axi_awvalid_i = 1'b0;
        n_checks++;
        if (!ok) begin
            $display("FAIL aw_handshake: awready=0 required 1 addr=%h", a);
            n_fail++;
        end
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s,
                          input logic l);
        bit ok;
        ok = 1'b0;
        axi_wdata_i  = d;
        axi_wstrb_i  = s;
        axi_wlast_i  = l;
        axi_wvalid_i = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if (axi_wready_o) ok = 1'b1;
            tick();
        end
        axi_wvalid_i = 1'b0;
        n_checks++;
        if (!ok) begin
            $display("FAIL w_handshake: wready=0 required 1 data=%h", d);
            n_fail++;
        end
    endtask

    task automatic recv_r(output logic [31:0] d, output logic [1:0] r,
                          output logic [3:0] id, output logic l);
        bit ok;
        ok = 1'b0;
        d  = 32'hx;
        r  = 2'bx;
        id = 4'hx;
        l  = 1'bx;
        axi_rready_i = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            #1;
            if (axi_rvalid_o) begin
                ok = 1'b1;
                d  = axi_rdata_o;
                r  = axi_rresp_o;
                id = axi_rid_o;
                l  = axi_rlast_o;
            end
            tick();
        end
        axi_rready_i = 1'b0;
        n_checks++;
        if (!ok) begin
            $display("FAIL r_wait: rvalid=0 required 1 within budget");
            n_fail++;
        end
    endtask

    task automatic recv_b(output logic [1:0] r, output logic [3:0] id);
        bit ok;
        ok = 1'b0;
        r  = 2'bx;
        id = 4'hx;
        axi_bready_i = 1'b1;
        for (int i = 0; i < 80 && !ok; i++) begin
            #1;
            if (axi_bvalid_o) begin
                ok = 1'b1;
                r  = axi_bresp_o;
                id = axi_bid_o;
            end
            tick();
        end
        axi_bready_i = 1'b0;
        n_checks++;
        if (!ok) begin
            $display("FAIL b_wait: bvalid=0 required 1 within budget");
            n_fail++;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        axi_awvalid_i = 1'b1;
        axi_arvalid_i = 1'b1;
        repeat (3) tick();
        n_checks += 12;
        if (axi_awready_o !== 1'b0) begin $display("FAIL rst_awready: %b vs 0", axi_awready_o); n_fail++; end
        if (axi_arready_o !== 1'b0) begin $display("FAIL rst_arready: %b vs 0", axi_arready_o); n_fail++; end
        if (axi_wready_o !== 1'b0) begin $display("FAIL rst_wready: %b vs 0", axi_wready_o); n_fail++; end
        if (axi_bvalid_o !== 1'b0) begin $display("FAIL rst_bvalid: %b vs 0", axi_bvalid_o); n_fail++; end
        if (axi_rvalid_o !== 1'b0) begin $display("FAIL rst_rvalid: %b vs 0", axi_rvalid_o); n_fail++; end
        if (wb_cyc_o !== 1'b0) begin $display("FAIL rst_cyc: %b vs 0", wb_cyc_o); n_fail++; end
        if (wb_stb_o !== 1'b0) begin $display("FAIL rst_stb: %b vs 0", wb_stb_o); n_fail++; end
        if (wb_we_o !== 1'b0) begin $display("FAIL rst_we: %b vs 0", wb_we_o); n_fail++; end
        if (wb_sel_o !== 4'h0) begin $display("FAIL rst_sel: %h vs 0", wb_sel_o); n_fail++; end
        if (wb_addr_o !== 32'h0) begin $display("FAIL rst_addr: %h vs 0", wb_addr_o); n_fail++; end
        if (axi_rdata_o !== 32'h0) begin $display("FAIL rst_rdata: %h vs 0", axi_rdata_o); n_fail++; end
        if (axi_rlast_o !== 1'b0) begin $display("FAIL rst_rlast: %b vs 0", axi_rlast_o); n_fail++; end
        axi_awvalid_i = 1'b0;
        axi_arvalid_i = 1'b0;
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        logic [31:0] d;
        logic [1:0]  r;
        logic [3:0]  id;
        logic        l;
        ack_en    = 1'b1;
        ack_delay = 2;
        rd_base   = 32'hDEADBEEF;
        n_log     = 0;
        send_ar(32'h100, 4'd3, 8'd0, 2'b01);
        n_checks += 2;
        if (wb_stb_o !== 1'b1) begin $display("FAIL rd_stb_latency: %b vs 1", wb_stb_o); n_fail++; end
        if (wb_sel_o !== 4'hF) begin $display("FAIL rd_sel: %h vs F", wb_sel_o); n_fail++; end
        recv_r(d, r, id, l);
        n_checks += 6;
        if (d !== 32'hDEADBEEF) begin $display("FAIL rd_data: %h vs DEADBEEF", d); n_fail++; end
        if (id !== 4'd3) begin $display("FAIL rd_id: %h vs 3", id); n_fail++; end
        if (r !== 2'b00) begin $display("FAIL rd_resp: %b vs 00", r); n_fail++; end
        if (l !== 1'b1) begin $display("FAIL rd_last: %b vs 1", l); n_fail++; end
        if (log_addr[0] !== 32'h100) begin $display("FAIL rd_wb_addr: %h vs 100", log_addr[0]); n_fail++; end
        if (log_we[0] !== 1'b0) begin $display("FAIL rd_wb_we: %b vs 0", log_we[0]); n_fail++; end
    endtask

    task automatic test_incr_write();
        logic [1:0] r;
        logic [3:0] id;
        ack_delay = 0;
        n_log     = 0;
        send_aw(32'h200, 4'd5, 8'd3, 2'b01);
        for (int i = 0; i < 4; i++) begin
            send_w(32'hA000_0000 + 32'(i), 4'b0011, i == 3);
        end
        recv_b(r, id);
        n_checks += 3;
        if (r !== 2'b00) begin $display("FAIL wr_bresp: %b vs 00", r); n_fail++; end
        if (id !== 4'd5) begin $display("FAIL wr_bid: %h vs 5", id); n_fail++; end
        if (n_log !== 4) begin $display("FAIL wr_beats: %0d vs 4", n_log); n_fail++; end
        for (int i = 0; i < 4; i++) begin
            n_checks += 4;
            if (log_addr[i] !== 32'h200 + 32'(4 * i)) begin $display("FAIL wr_addr[%0d]: %h vs %h", i, log_addr[i], 32'h200 + 32'(4 * i)); n_fail++; end
            if (log_sel[i] !== 4'b0011) begin $display("FAIL wr_sel[%0d]: %b vs 0011", i, log_sel[i]); n_fail++; end
            if (log_we[i] !== 1'b1) begin $display("FAIL wr_we[%0d]: %b vs 1", i, log_we[i]); n_fail++; end
            if (log_data[i] !== 32'hA000_0000 + 32'(i)) begin $display("FAIL wr_data[%0d]: %h vs %h", i, log_data[i], 32'hA000_0000 + 32'(i)); n_fail++; end
        end
        repeat (3) tick();
        n_checks++;
        if (axi_bvalid_o !== 1'b0) begin $display("FAIL wr_single_b: bvalid %b vs 0", axi_bvalid_o); n_fail++; end
    endtask

    task automatic test_wlast_err();
        logic [1:0] r;
        logic [3:0] id;
        send_aw(32'h280, 4'd6, 8'd1, 2'b01);
        send_w(32'h1, 4'hF, 1'b1);
        send_w(32'h2, 4'hF, 1'b1);
        recv_b(r, id);
        n_checks++;
        if (r !== 2'b10) begin $display("FAIL wlast_err_bresp: %b vs 10", r); n_fail++; end
    endtask

    task automatic test_arbitration();
        logic [1:0]  r;
        logic [3:0]  id;
        logic [31:0] d;
        logic        l;
        rst_i = 1'b1;
        repeat (2) tick();
        rst_i = 1'b0;
        axi_awaddr_i = 32'h500; axi_awid_i = 4'd1; axi_awlen_i = 8'd0; axi_awburst_i = 2'b01;
        axi_araddr_i = 32'h600; axi_arid_i = 4'd2; axi_arlen_i = 8'd0; axi_arburst_i = 2'b01;
        axi_awvalid_i = 1'b1;
        axi_arvalid_i = 1'b1;
        #1;
        n_checks += 2;
        if (axi_awready_o !== 1'b1) begin $display("FAIL arb1_awready: %b vs 1", axi_awready_o); n_fail++; end
        if (axi_arready_o !== 1'b0) begin $display("FAIL arb1_arready: %b vs 0", axi_arready_o); n_fail++; end
        tick();
        axi_awvalid_i = 1'b0;
        send_w(32'h55, 4'hF, 1'b1);
        recv_b(r, id);
        axi_awaddr_i  = 32'h504;
        axi_awid_i    = 4'd4;
        axi_awvalid_i = 1'b1;
        #1;
        n_checks += 3;
        if (id !== 4'd1) begin $display("FAIL arb1_bid: %h vs 1", id); n_fail++; end
        if (axi_arready_o !== 1'b1) begin $display("FAIL arb2_arready: %b vs 1", axi_arready_o); n_fail++; end
        if (axi_awready_o !== 1'b0) begin $display("FAIL arb2_awready: %b vs 0", axi_awready_o); n_fail++; end
        tick();
        axi_arvalid_i = 1'b0;
        recv_r(d, r, id, l);
        #1;
        n_checks += 2;
        if (id !== 4'd2) begin $display("FAIL arb2_rid: %h vs 2", id); n_fail++; end
        if (axi_awready_o !== 1'b1) begin $display("FAIL arb3_awready: %b vs 1", axi_awready_o); n_fail++; end
        tick();
        axi_awvalid_i = 1'b0;
        send_w(32'h66, 4'hF, 1'b1);
        recv_b(r, id);
        n_checks++;
        if (id !== 4'd4) begin $display("FAIL arb3_bid: %h vs 4", id); n_fail++; end
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        logic [1:0]  r;
        logic [3:0]  id;
        logic        l;
        ack_en  = 1'b0;
        stb_cnt = 0;
        send_ar(32'h300, 4'd7, 8'd0, 2'b01);
        recv_r(d, r, id, l);
        n_checks += 3;
        if (r !== 2'b10) begin $display("FAIL tmo_rresp: %b vs 10", r); n_fail++; end
        if (d !== 32'h0) begin $display("FAIL tmo_rdata: %h vs 0", d); n_fail++; end
        if (stb_cnt !== 8) begin $display("FAIL tmo_stb_cycles: %0d vs 8", stb_cnt); n_fail++; end
        send_aw(32'h310, 4'd8, 8'd0, 2'b01);
        send_w(32'h77, 4'hF, 1'b1);
        recv_b(r, id);
        n_checks++;
        if (r !== 2'b10) begin $display("FAIL tmo_bresp: %b vs 10", r); n_fail++; end
        ack_en = 1'b1;
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        logic [1:0]  r;
        logic [3:0]  id;
        logic        l;
        logic [31:0] exp_a[4];
        logic [1:0]  exp_r;
`ifdef AXI_WB_WRAP_EN
        exp_a = '{32'h38, 32'h3C, 32'h30, 32'h34};
        exp_r = 2'b00;
`else
        exp_a = '{32'h38, 32'h38, 32'h38, 32'h38};
        exp_r = 2'b10;
`endif
        ack_delay = 0;
        n_log     = 0;
        send_ar(32'h38, 4'd9, 8'd3, 2'b10);
        for (int i = 0; i < 4; i++) begin
            recv_r(d, r, id, l);
            n_checks += 3;
            if (r !== exp_r) begin $display("FAIL wrap_resp[%0d]: %b vs %b", i, r, exp_r); n_fail++; end
            if (l !== (i == 3)) begin $display("FAIL wrap_last[%0d]: %b vs %b", i, l, i == 3); n_fail++; end
            if (log_addr[i] !== exp_a[i]) begin $display("FAIL wrap_addr[%0d]: %h vs %h", i, log_addr[i], exp_a[i]); n_fail++; end
        end
        n_log = 0;
        send_ar(32'h40, 4'd1, 8'd1, 2'b11);
        for (int i = 0; i < 2; i++) begin
            recv_r(d, r, id, l);
            n_checks += 2;
            if (r !== 2'b10) begin $display("FAIL rsvd_resp[%0d]: %b vs 10", i, r); n_fail++; end
            if (log_addr[i] !== 32'h40) begin $display("FAIL rsvd_addr[%0d]: %h vs 40", i, log_addr[i]); n_fail++; end
        end
    endtask

    task automatic test_reset_midburst();
        logic [31:0] d;
        logic [1:0]  r;
        logic [3:0]  id;
        logic        l;
        int          seen;
        ack_delay = 4;
        rd_base   = 32'h1234_0000;
        n_log     = 0;
        send_ar(32'h400, 4'd9, 8'd7, 2'b01);
        recv_r(d, r, id, l);
        n_checks += 2;
        if (d !== 32'h1234_0000) begin $display("FAIL mid_beat0_data: %h vs 12340000", d); n_fail++; end
        if (l !== 1'b0) begin $display("FAIL mid_beat0_last: %b vs 0", l); n_fail++; end
        recv_r(d, r, id, l);
        n_checks += 3;
        if (d !== 32'h1234_0001) begin $display("FAIL mid_beat1_data: %h vs 12340001", d); n_fail++; end
        if (log_addr[1] !== 32'h404) begin $display("FAIL mid_beat1_addr: %h vs 404", log_addr[1]); n_fail++; end
        if (wb_stb_o !== 1'b1) begin $display("FAIL mid_beat2_stb: %b vs 1", wb_stb_o); n_fail++; end
        rst_i = 1'b1;
        tick();
        n_checks += 3;
        if (wb_cyc_o !== 1'b0) begin $display("FAIL mid_cyc: %b vs 0", wb_cyc_o); n_fail++; end
        if (wb_stb_o !== 1'b0) begin $display("FAIL mid_stb: %b vs 0", wb_stb_o); n_fail++; end
        if (axi_rvalid_o !== 1'b0) begin $display("FAIL mid_rvalid: %b vs 0", axi_rvalid_o); n_fail++; end
        rst_i = 1'b0;
        axi_rready_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (axi_rvalid_o || wb_cyc_o) seen++;
        end
        axi_rready_i = 1'b0;
        n_checks++;
        if (seen !== 0) begin $display("FAIL mid_no_more_beats: %0d active cycles vs 0", seen); n_fail++; end
    endtask

    initial begin
        rst_i = 1'b1;
        axi_awvalid_i = 1'b0; axi_awaddr_i = '0; axi_awid_i = '0;
        axi_awlen_i = '0; axi_awburst_i = '0;
        axi_wvalid_i = 1'b0; axi_wdata_i = '0; axi_wstrb_i = '0; axi_wlast_i = 1'b0;
        axi_bready_i = 1'b0;
        axi_arvalid_i = 1'b0; axi_araddr_i = '0; axi_arid_i = '0;
        axi_arlen_i = '0; axi_arburst_i = '0;
        axi_rready_i = 1'b0;
        ack_en = 1'b1; ack_delay = 0; rd_base = 32'h0;
        n_log = 0; stb_cnt = 0;
        test_reset();
        test_single_read();
        test_incr_write();
        test_wlast_err();
        test_arbitration();
        test_timeout();
        test_wrap();
        test_reset_midburst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
